// File: rtl/alu_pkg.sv
// Shared types and constants for the SPI calculator execution stage.
// ALU_ITER_DIV_EN selects whether DIV/MOD take the iterative path or are rejected as illegal.
package alu_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_SHL = 4'b0101,
        OP_SHR = 4'b0110,
        OP_MUL = 4'b1000,
        OP_DIV = 4'b1100,
        OP_MOD = 4'b1101
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_ITER_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/spi_alu_exec_if.sv
// Frame-in / result-out handshake bundle between the SPI shifters and the execution stage.
interface spi_alu_exec_if #(parameter int W = 4);
    logic           in_valid;
    logic           in_ready;
    logic [3*W-1:0] in_frame;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   result;
    logic [3:0]     flags;
    logic           err;
    logic [3:0]     leds;

    modport slave (
        input  in_valid, in_frame, out_ready,
        output in_ready, out_valid, result, flags, err, leds
    );

    modport master (
        output in_valid, in_frame, out_ready,
        input  in_ready, out_valid, result, flags, err, leds
    );
endinterface

// File: rtl/alu_iter_unit.sv
// W-cycle shift-add multiplier and restoring divider sharing one 2W shift register and counter.
// Divider datapath and its ports exist only when ALU_ITER_DIV_EN is defined.
module alu_iter_unit #(parameter int W = 4) (
    input  logic           clk_arduino,
    input  logic           reset,
    input  logic           start,
`ifdef ALU_ITER_DIV_EN
    input  logic           div_mode,
    output logic           div_zero,
`endif
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] res
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] sr_q, sr_d, sr_step;
    logic [W-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [W:0]     mul_sum;
`ifdef ALU_ITER_DIV_EN
    logic           div_q, div_d;
    logic [W:0]     div_trial;
    logic [W-1:0]   div_diff;
`endif

    // One iteration; outputs expose the post-step value so the top can latch it on the final edge.
    always_comb begin
        mul_sum = {1'b0, sr_q[2*W-1:W]} + (sr_q[0] ? {1'b0, b_q} : '0);
        sr_step = {mul_sum, sr_q[W-1:1]};
`ifdef ALU_ITER_DIV_EN
        div_trial = {sr_q[2*W-1:W], sr_q[W-1]};
        div_diff  = W'(div_trial - {1'b0, b_q});
        if (div_q) begin
            if (div_trial >= {1'b0, b_q}) sr_step = {div_diff, sr_q[W-2:0], 1'b1};
            else                          sr_step = {div_trial[W-1:0], sr_q[W-2:0], 1'b0};
        end
`endif
    end

    assign done = busy_q && (cnt_q == CW'(W - 1));
    assign res  = sr_step;
`ifdef ALU_ITER_DIV_EN
    assign div_zero = (b_q == '0);
`endif

    always_comb begin
        sr_d   = sr_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
`ifdef ALU_ITER_DIV_EN
        div_d  = div_q;
`endif
        if (start) begin
            sr_d   = {{W{1'b0}}, a};
            b_d    = b;
            cnt_d  = '0;
            busy_d = 1'b1;
`ifdef ALU_ITER_DIV_EN
            div_d  = div_mode;
`endif
        end else if (busy_q) begin
            sr_d   = sr_step;
            cnt_d  = done ? '0 : cnt_q + CW'(1);
            busy_d = !done;
        end
    end

    always_ff @(posedge clk_arduino) begin
        if (reset) begin
            sr_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            sr_q   <= sr_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef ALU_ITER_DIV_EN
            div_q  <= div_d;
`endif
        end
    end
endmodule

// File: rtl/spi_alu_exec.sv
// SPI calculator execution stage: IDLE/EXEC/DONE control, single-cycle ALU, result and LED registers.
// ALU_ITER_DIV_EN enables DIV/MOD through the iterative unit; otherwise they are illegal opcodes.
module spi_alu_exec import alu_pkg::*; #(parameter int W = W_DEF) (
    input  logic        clk_arduino,
    input  logic        reset,
    spi_alu_exec_if.slave bus
);
    logic [W-1:0]   a_in, b_in;
    logic [3:0]     op_in;
    state_e         state_q, state_d;
    logic           in_ready_c, accept, iter_start, load_simple, load_iter, iter_done;
    logic [2*W-1:0] iter_res;
    logic [W-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d, leds_q, leds_d;
    logic           err_q, err_d;
    logic [W-1:0]   s_res, f_res;
    logic           s_c, s_v, s_err, f_c, f_v, f_err;
    logic [W:0]     add_w, sub_w, shl_w;
    logic [1:0]     sh;
`ifdef ALU_ITER_DIV_EN
    logic           iter_dz;
    logic [3:0]     op_q, op_d;
`endif

    assign a_in  = bus.in_frame[3*W-1:2*W];
    assign b_in  = bus.in_frame[2*W-1:W];
    assign op_in = bus.in_frame[3:0];

    always_ff @(posedge clk_arduino) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_iter_op(op_in) ? EXEC : DONE;
            EXEC:    if (iter_done) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state_q == IDLE) && !reset;
        accept      = bus.in_valid && in_ready_c;
        iter_start  = accept && is_iter_op(op_in);
        load_simple = accept && !is_iter_op(op_in);
        load_iter   = (state_q == EXEC) && iter_done;
    end

    alu_iter_unit #(.W(W)) u_iter (
        .clk_arduino (clk_arduino),
        .reset       (reset),
        .start       (iter_start),
`ifdef ALU_ITER_DIV_EN
        .div_mode    ((op_in == OP_DIV) || (op_in == OP_MOD)),
        .div_zero    (iter_dz),
`endif
        .a           (a_in),
        .b           (b_in),
        .done        (iter_done),
        .res         (iter_res)
    );

    // Single-cycle ALU works straight off the incoming frame so it can be latched on the accept edge.
    always_comb begin
        add_w = {1'b0, a_in} + {1'b0, b_in};
        sub_w = {1'b0, a_in} - {1'b0, b_in};
        sh    = b_in[1:0];
        shl_w = {1'b0, a_in} << sh;
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_err = 1'b0;
        case (op_in)
            OP_ADD: begin
                s_res = add_w[W-1:0];
                s_c   = add_w[W];
                s_v   = (a_in[W-1] == b_in[W-1]) && (add_w[W-1] != a_in[W-1]);
            end
            OP_SUB: begin
                s_res = sub_w[W-1:0];
                s_c   = sub_w[W];
                s_v   = (a_in[W-1] != b_in[W-1]) && (sub_w[W-1] != a_in[W-1]);
            end
            OP_AND: s_res = a_in & b_in;
            OP_OR:  s_res = a_in | b_in;
            OP_XOR: s_res = a_in ^ b_in;
            OP_SHL: begin
                s_res = shl_w[W-1:0];
                s_c   = shl_w[W];
            end
            OP_SHR: s_res = a_in >> sh;
            default: s_err = 1'b1;
        endcase
    end

    always_comb begin
        f_res = s_res;
        f_c   = s_c;
        f_v   = s_v;
        f_err = s_err;
        if (load_iter) begin
            f_res = iter_res[W-1:0];
            f_c   = |iter_res[2*W-1:W];
            f_v   = 1'b0;
            f_err = 1'b0;
`ifdef ALU_ITER_DIV_EN
            if ((op_q == OP_DIV) || (op_q == OP_MOD)) begin
                f_res = iter_dz ? '1 : ((op_q == OP_MOD) ? iter_res[2*W-1:W] : iter_res[W-1:0]);
                f_c   = 1'b0;
                f_v   = iter_dz;
                f_err = iter_dz;
            end
`endif
        end
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        leds_d   = leds_q;
        if (load_simple || load_iter) begin
            result_d        = f_res;
            flags_d[FLAG_N] = f_res[W-1];
            flags_d[FLAG_Z] = (f_res == '0);
            flags_d[FLAG_C] = f_c;
            flags_d[FLAG_V] = f_v;
            err_d           = f_err;
            leds_d          = flags_d;
        end
`ifdef ALU_ITER_DIV_EN
        op_d = accept ? op_in : op_q;
`endif
    end

    always_ff @(posedge clk_arduino) begin
        if (reset) begin
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            leds_q   <= '0;
`ifdef ALU_ITER_DIV_EN
            op_q     <= '0;
`endif
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            leds_q   <= leds_d;
`ifdef ALU_ITER_DIV_EN
            op_q     <= op_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
    assign bus.leds      = leds_q;
endmodule

// File: tb/tb_spi_alu_exec.sv
// Self-checking bench for spi_alu_exec: spec vectors, randomized ops vs. arithmetic model, corner sequences.
module tb_spi_alu_exec;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_alu_exec_if #(.W(4)) bus();

    spi_alu_exec #(.W(4)) dut (
        .clk_arduino (clk),
        .reset       (reset),
        .bus         (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] a, b, op;
        logic [3:0] res, flags;
        logic       err;
        int         lat;
    } vec_t;

    typedef struct {
        logic [3:0] res, flags;
        logic       err;
        int         lat;
    } exp_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int r, sa, sb, sh;
        bit c, v, er;
        int lat;
        r = 0; c = 0; v = 0; er = 0; lat = 1;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        sh = b % 4;
        case (op)
            0: begin r = a + b; c = (r > 15); v = (sa + sb > 7) || (sa + sb < -8); end
            1: begin r = a - b; c = (a < b);  v = (sa - sb > 7) || (sa - sb < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * (1 << sh); c = ((r / 16) % 2) == 1; end
            6: r = a / (1 << sh);
            8: begin r = a * b; c = (r >= 16); lat = 5; end
`ifdef ALU_ITER_DIV_EN
            12, 13: begin
                lat = 5;
                if (b == 0) begin r = 15; v = 1; er = 1; end
                else r = (op == 12) ? a / b : a % b;
            end
`endif
            default: begin r = 0; er = 1; end
        endcase
        r = ((r % 16) + 16) % 16;
        e.res   = 4'(r);
        e.flags = {(r >= 8), (r == 0), c, v};
        e.err   = er;
        e.lat   = lat;
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        @(negedge clk);
        bus.in_frame = {a, b, op};
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                          input logic [3:0] er, input logic [3:0] ef, input logic ee, input int el);
        int lat;
        wait_ready();
        issue(a, b, op);
        wait_valid(lat);
        check("latency", lat, el);
        check("result", bus.result, er);
        check("flags", bus.flags, ef);
        check("err", bus.err, ee);
        check("leds", bus.leds, ef);
        $display("op=%b a=%0d b=%0d result=%0d flags=%b err=%b leds=%b latency=%0d",
                 op, a, b, bus.result, bus.flags, bus.err, bus.leds, lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_done", bus.in_ready, 1);
        check("out_valid_after_done", bus.out_valid, 0);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        exp_t e;
        logic [3:0] ra, rb, rop;

        vecs[0]  = '{a:12, b:6,  op:4'b0000, res:2,  flags:4'b0010, err:0, lat:1};
        vecs[1]  = '{a:3,  b:5,  op:4'b0001, res:14, flags:4'b1010, err:0, lat:1};
        vecs[2]  = '{a:6,  b:6,  op:4'b1000, res:4,  flags:4'b0010, err:0, lat:5};
        vecs[3]  = '{a:0,  b:0,  op:4'b1111, res:0,  flags:4'b0100, err:1, lat:1};
        vecs[4]  = '{a:7,  b:1,  op:4'b0000, res:8,  flags:4'b1001, err:0, lat:1};
        vecs[5]  = '{a:6,  b:2,  op:4'b0101, res:8,  flags:4'b1010, err:0, lat:1};
        vecs[6]  = '{a:12, b:3,  op:4'b0110, res:1,  flags:4'b0000, err:0, lat:1};
        vecs[7]  = '{a:6,  b:6,  op:4'b0100, res:0,  flags:4'b0100, err:0, lat:1};
        vecs[8]  = '{a:5,  b:10, op:4'b0011, res:15, flags:4'b1000, err:0, lat:1};
`ifdef ALU_ITER_DIV_EN
        vecs[9]  = '{a:12, b:6,  op:4'b1100, res:2,  flags:4'b0000, err:0, lat:5};
        vecs[10] = '{a:11, b:3,  op:4'b1101, res:2,  flags:4'b0000, err:0, lat:5};
        vecs[11] = '{a:9,  b:0,  op:4'b1100, res:15, flags:4'b1001, err:1, lat:5};
`else
        vecs[9]  = '{a:12, b:6,  op:4'b1100, res:0,  flags:4'b0100, err:1, lat:1};
        vecs[10] = '{a:11, b:3,  op:4'b1101, res:0,  flags:4'b0100, err:1, lat:1};
        vecs[11] = '{a:9,  b:0,  op:4'b1100, res:0,  flags:4'b0100, err:1, lat:1};
`endif

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_frame  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", bus.flags, 0);
        check("rst_err", bus.err, 0);
        check("rst_leds", bus.leds, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        $display("reset released in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].flags, vecs[i].err, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            e   = model(int'(ra), int'(rb), int'(rop));
            run_op(ra, rb, rop, e.res, e.flags, e.err, e.lat);
        end

        // Backpressure: DONE held six cycles while in_valid pulses are ignored.
        wait_ready();
        issue(4'd12, 4'd6, 4'b0000);
        wait_valid(lat);
        check("bp_latency", lat, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_frame = {4'd3, 4'd5, 4'b0001};
            bus.in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_result", bus.result, 2);
            check("bp_flags", bus.flags, 4'b0010);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_in_ready_return", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("bp_not_queued", bus.out_valid, 0);
        check("bp_result_held", bus.result, 2);
        $display("backpressure result=%0d flags=%b in_ready=%b out_valid=%b",
                 bus.result, bus.flags, bus.in_ready, bus.out_valid);

        // Reset on the second EXEC cycle of a MUL aborts it.
        run_op(4'd7, 4'd1, 4'b0000, 4'd8, 4'b1001, 1'b0, 1);
        wait_ready();
        issue(4'd6, 4'd6, 4'b1000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_result", bus.result, 0);
        check("mid_rst_flags", bus.flags, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_leds", bus.leds, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_aborted", bus.out_valid, 0);
        check("mid_rst_result_kept", bus.result, 0);
        $display("mid-exec reset result=%0d flags=%b out_valid=%b", bus.result, bus.flags, bus.out_valid);
        run_op(4'd1, 4'd1, 4'b0000, 4'd2, 4'b0000, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spi_alu_exec.md
# spi_alu_exec

Downstream execution stage of the SPI calculator slave. Accepts one decoded 12-bit frame {operand_1, operand_2, operator} from the SPI receive shifter. Computes a 4-bit result plus flags, using single-cycle logic for simple ops and an iterative unit for MUL/DIV/MOD. Holds the result for the MISO transmit shifter and drives the four status LEDs.

## Interface
- W, 4, operand/result width; frame width is 3*W, opcode width fixed at 4
- clk_arduino  in  1  single system clock, rising-edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  frame available from SPI receiver
- in_ready  out  1  block can accept a frame (high only in IDLE)
- in_frame  in  3*W  bits [3W-1:2W]=operand_1, [2W-1:W]=operand_2, [3:0]=operator
- out_valid  out  1  result/flags valid, held until consumed
- out_ready  in  1  transmit shifter takes result
- result  out  W  operation result, low W bits
- flags  out  4  {N,Z,C,V}
- err  out  1  illegal opcode or divide-by-zero on current result
- leds  out  4  copy of flags, registered, updated on every completed op

## Operation
- Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 SHL (a<<b[1:0]), 0110 SHR logical, 1000 MUL, 1100 DIV (a/b unsigned), 1101 MOD (a%b); all others illegal.
- FSM: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid, capture frame. Single-cycle op goes to DONE; MUL/DIV/MOD go to EXEC.
  - EXEC: iterative unit runs exactly W cycles (shift-add multiply, restoring divide), then DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Flags:
  - N = result[W-1].
  - Z = (result==0).
  - C: ADD carry out; SUB borrow (a<b); MUL high W bits nonzero; SHL last bit shifted out; 0 otherwise.
  - V: ADD/SUB signed overflow; DIV/MOD divide-by-zero; 0 otherwise.
- Divide by zero: result=all ones, V=1, err=1, still exactly W EXEC cycles.
- Illegal opcode: result=0, flags={0,1,0,0}, err=1, single-cycle path.
- result/flags/err/leds update only on entry to DONE. They are stable through DONE and held after return to IDLE.

## Timing
- Reset values: in_ready=0 during reset then 1, out_valid=0, result=0, flags=0, err=0, leds=0, state=IDLE, iterative counter=0.
- Accept on the rising edge where in_valid&&in_ready.
- Single-cycle op: out_valid high the following cycle (latency 1).
- Iterative op: out_valid high W+1 cycles after accept (5 for W=4).
- Handshake completes on the edge where out_valid&&out_ready; in_ready rises the next cycle. No back-to-back accept in DONE.
- Throughput: ≥1 frame per 2 cycles (simple ops) or per W+2 cycles (iterative).
- in_valid is ignored while in_ready=0; no frame is queued.
- reset asserted in any state, including mid-EXEC, aborts on that edge. All outputs take reset values; the partial result is discarded.
- out_ready held low: DONE persists indefinitely with no output change.

## Configuration
- ALU_ITER_DIV_EN defined: DIV/MOD supported via the iterative divider path.
- ALU_ITER_DIV_EN undefined: divider logic removed; 1100/1101 are treated as illegal (result 0, err=1, latency 1). MUL remains iterative.

## Structure
- Package alu_pkg holds:
  - opcode enum (4-bit)
  - state enum {IDLE,EXEC,DONE}
  - flag bit index constants N/Z/C/V
  - default W=4
- Sub-module alu_iter_unit: start/done interface, W-cycle shift-add multiplier and restoring divider sharing one shift register and counter. Outputs a 2W product or quotient/remainder plus a div-by-zero flag.
- Top contains FSM, single-cycle ALU, and output/LED registers.

## Test plan
- DIV 12/6 (frame 1100_0110_1100, ALU_ITER_DIV_EN): result=2, flags=0000, err=0, out_valid 5 cycles after accept.
- ADD 12+6: result=2, C=1, V=0, N=0, Z=0, latency 1. SUB 3-5: result=14, N=1, C=1, V=0.
- MUL 6*6: result=4, C=1, latency 5. MOD 11%3: result=2.
- DIV 9/0: result=15, V=1, err=1. Opcode 1111: result=0, Z=1, err=1, latency 1.
- Backpressure: out_ready low 6 cycles in DONE. result/flags stable, in_ready=0, in_valid pulses ignored. On out_ready, in_ready returns next cycle.
- reset pulse on cycle 2 of EXEC: all outputs zero next cycle. A subsequent ADD 1+1 gives result=2 normally.
- Build without ALU_ITER_DIV_EN: DIV 12/6 gives result=0, err=1, latency 1.
